program_run_ctrl: RTL and testbench

//  Sequencer in front of ARMProcessor: accepts a byte stream, assembles 32-bit words, writes them into

---
 rtl/calcutec_pkg.sv | 24 ++
 rtl/byte_word_assembler.sv | 42 ++++
 rtl/program_run_ctrl.sv | 163 ++++++++++++++++
 tb/tb_program_run_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calcutec_pkg.sv
// Shared types and constants for the program-load/run sequencer in front of the CPU.
package calcutec_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    localparam logic [3:0]  B_SELF_OPC = 4'b1010;
    localparam logic [23:0] B_SELF_IMM = 24'hFFFFFE;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
        LOADED  = 3'd3,
        RUN     = 3'd4,
        DONE    = 3'd5
    } state_e;

    // Branch-always to its own address: the program's conventional "halt here".
    function automatic logic is_b_self(input logic [27:0] w);
        return (w[27:24] == B_SELF_OPC) && (w[23:0] == B_SELF_IMM);
    endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// Shifts accepted bytes MSB-first into a word; flags the byte that completes a word.
module byte_word_assembler #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_en,
    input  logic [7:0]        byte_data,
    output logic [DATA_W-1:0] word,
    output logic              word_valid
);
    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [DATA_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic              last_byte;

    assign last_byte  = (byte_idx_q == IDX_W'(BYTES - 1));
    assign word_valid = byte_en && last_byte;
    assign word       = word_q;

    always_comb begin
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        if (byte_en) begin
            word_d     = {word_q[DATA_W-9:0], byte_data};
            byte_idx_d = last_byte ? '0 : byte_idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q     <= '0;
            byte_idx_q <= '0;
        end else begin
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
        end
    end

endmodule

// File: rtl/program_run_ctrl.sv
// Loads a byte-streamed program into instruction memory, then grants the CPU a bounded run.
// Define HALT_SELF_BRANCH_EN to also end a run when pc reaches the first B-to-self instruction.
module program_run_ctrl
    import calcutec_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RUN_CYCLES = 64,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic              start_run,
    input  logic [ADDR_W-1:0] pc,
    output logic              write_ins,
    output logic [ADDR_W-1:0] ins_address,
    output logic [DATA_W-1:0] ins,
    output logic              cpu_clk_en,
    output logic              busy,
    output logic              done
);
    localparam int NW_W      = ADDR_W + 1;
    localparam int MAX_WORDS = 2 ** ADDR_W;

    state_e            state_q, state_d;
    logic [NW_W-1:0]   n_q, n_d, word_idx_q, word_idx_d;
    logic [ADDR_W-1:0] ins_address_q, ins_address_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              byte_ready_q, write_ins_q, cpu_clk_en_q, busy_q, done_q;
    logic              byte_fire, count_fire, asm_en, word_valid, halt_hit;
    logic [DATA_W-1:0] ins_w;

    assign byte_fire  = byte_valid && byte_ready_q;
    assign count_fire = byte_fire && (state_q == IDLE) && (byte_data != 8'd0);
    assign asm_en     = byte_fire && (state_q == COLLECT);

    byte_word_assembler #(.DATA_W(DATA_W)) u_asm (
        .clk        (clk),
        .rst        (rst),
        .byte_en    (asm_en),
        .byte_data  (byte_data),
        .word       (ins_w),
        .word_valid (word_valid)
    );

`ifdef HALT_SELF_BRANCH_EN
    logic              halt_valid_q, halt_valid_d;
    logic [ADDR_W-1:0] halt_addr_q, halt_addr_d;

    // Addresses are written in ascending order, so the first match is the lowest one.
    always_comb begin
        halt_valid_d = halt_valid_q;
        halt_addr_d  = halt_addr_q;
        if (count_fire) begin
            halt_valid_d = 1'b0;
        end else if (state_q == WRITE && !halt_valid_q && is_b_self(ins_w[27:0])) begin
            halt_valid_d = 1'b1;
            halt_addr_d  = ins_address_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            halt_valid_q <= 1'b0;
            halt_addr_q  <= '0;
        end else begin
            halt_valid_q <= halt_valid_d;
            halt_addr_q  <= halt_addr_d;
        end
    end

    assign halt_hit = halt_valid_q && (pc == halt_addr_q);
`else
    logic unused_pc;
    assign unused_pc = ^pc;
    assign halt_hit  = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        n_d           = n_q;
        word_idx_d    = word_idx_q;
        ins_address_d = ins_address_q;
        cnt_d         = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (count_fire) begin
                    n_d        = (32'(byte_data) > MAX_WORDS) ? NW_W'(MAX_WORDS) : NW_W'(byte_data);
                    word_idx_d = '0;
                    state_d    = COLLECT;
                end
            end
            COLLECT: begin
                if (word_valid) begin
                    ins_address_d = word_idx_q[ADDR_W-1:0];
                    state_d       = WRITE;
                end
            end
            WRITE: begin
                word_idx_d = word_idx_q + NW_W'(1);
                state_d    = (word_idx_q + NW_W'(1) == n_q) ? LOADED : COLLECT;
            end
            LOADED: begin
                if (start_run) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(RUN_CYCLES - 1) || halt_hit) state_d = DONE;
            end
            DONE: begin
                // A run request beats a pending byte; the byte is left for IDLE to take.
                if (start_run) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end else if (byte_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            n_q           <= '0;
            word_idx_q    <= '0;
            ins_address_q <= '0;
            cnt_q         <= '0;
            byte_ready_q  <= 1'b1;
            write_ins_q   <= 1'b0;
            cpu_clk_en_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            n_q           <= n_d;
            word_idx_q    <= word_idx_d;
            ins_address_q <= ins_address_d;
            cnt_q         <= cnt_d;
            byte_ready_q  <= (state_d == IDLE) || (state_d == COLLECT);
            write_ins_q   <= (state_d == WRITE);
            cpu_clk_en_q  <= (state_d == RUN);
            busy_q        <= !((state_d == IDLE) || (state_d == LOADED) || (state_d == DONE));
            done_q        <= (state_d == DONE);
        end
    end

    assign byte_ready  = byte_ready_q;
    assign write_ins   = write_ins_q;
    assign ins_address = ins_address_q;
    assign ins         = ins_w;
    assign cpu_clk_en  = cpu_clk_en_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_program_run_ctrl.sv
// Randomized bench for program_run_ctrl with a program-level reference model.
module tb_program_run_ctrl;
    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 32;
    localparam int RUN_CYCLES = 64;
    localparam int CNT_W      = 16;

    logic              clk = 1'b0;
    logic              rst, byte_valid, start_run;
    logic [7:0]        byte_data;
    logic [ADDR_W-1:0] pc;
    logic              byte_ready, write_ins, cpu_clk_en, busy, done;
    logic [ADDR_W-1:0] ins_address;
    logic [DATA_W-1:0] ins;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] prog_words [0:63];
    logic [4:0]  pc_seq [0:255];

    // Write-pulse log and protocol flags, owned by the monitor only.
    int          wr_cnt = 0;
    logic [4:0]  wr_addr_log [0:1023];
    logic [31:0] wr_data_log [0:1023];
    logic        prev_wr = 1'b0;
    logic        overlap_seen = 1'b0;
    logic        unstable_seen = 1'b0;

    program_run_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RUN_CYCLES(RUN_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .start_run(start_run), .pc(pc),
        .write_ins(write_ins), .ins_address(ins_address), .ins(ins),
        .cpu_clk_en(cpu_clk_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (prev_wr && (ins !== wr_data_log[wr_cnt-1] || ins_address !== wr_addr_log[wr_cnt-1]))
            unstable_seen <= 1'b1;
        if (write_ins && cpu_clk_en) overlap_seen <= 1'b1;
        if (write_ins === 1'b1 && wr_cnt < 1024) begin
            wr_addr_log[wr_cnt] <= ins_address;
            wr_data_log[wr_cnt] <= ins;
            wr_cnt <= wr_cnt + 1;
        end
        prev_wr <= (write_ins === 1'b1);
    end

    // Reference: enables granted = full budget unless pc hits the lowest B-to-self word first.
    function automatic int expected_enables(input int n);
        int res;
        res = RUN_CYCLES;
`ifdef HALT_SELF_BRANCH_EN
        begin
            int lowest;
            lowest = -1;
            for (int i = 0; i < n; i++)
                if (lowest < 0 && prog_words[i][27:24] == 4'hA && prog_words[i][23:0] == 24'hFFFFFE)
                    lowest = i;
            if (lowest >= 0)
                for (int k = RUN_CYCLES - 1; k >= 0; k--)
                    if (int'(pc_seq[k]) == lowest) res = k + 1;
        end
`else
        if (n < 0) res = 0;
`endif
        return res;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int   guard;
        logic acc;
        guard = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        do begin
            @(negedge clk);
            acc = byte_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 100);
        byte_valid = 1'b0;
        if (!acc) begin
            vectors++; miscompares++;
            $display("FAIL byte_accept_timeout: byte %h not accepted in %0d cycles, expected acceptance", b, guard);
        end
    endtask

    task automatic load_program(input int count_byte, input bit gaps);
        int n, base;
        n    = (count_byte == 0) ? 0 : ((count_byte > 32) ? 32 : count_byte);
        base = wr_cnt;
        send_byte(8'(count_byte));
        if (n == 0) begin
            @(negedge clk);
            vectors++;
            if ({byte_ready, busy, done} !== 3'b100 || wr_cnt != base) begin
                miscompares++;
                $display("FAIL zero_count: ready/busy/done=%b writes=%0d, expected 100 and 0", {byte_ready, busy, done}, wr_cnt - base);
            end
            @(posedge clk); #1;
            return;
        end
        for (int w = 0; w < n; w++) begin
            for (int b = 0; b < 4; b++) begin
                if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                send_byte(prog_words[w][31-8*b -: 8]);
            end
            @(negedge clk);
            vectors++;
            if (write_ins !== 1'b1 || ins_address !== 5'(w) || ins !== prog_words[w]) begin
                miscompares++;
                $display("FAIL write_word%0d: we=%b addr=%0d ins=%h, expected we=1 addr=%0d ins=%h",
                         w, write_ins, ins_address, ins, w, prog_words[w]);
            end
        end
        @(negedge clk);
        vectors++;
        if ({byte_ready, busy, done, write_ins} !== 4'b0000 || wr_cnt - base != n) begin
            miscompares++;
            $display("FAIL loaded_state: rdy/busy/done/we=%b writes=%0d, expected 0000 and %0d",
                     {byte_ready, busy, done, write_ins}, wr_cnt - base, n);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_run(input int exp_en, input bit collide);
        int   en, guard;
        logic rdy, busy_bad;
        en = 0; guard = 0; busy_bad = 1'b0;
        start_run = 1'b1;
        if (collide) begin byte_valid = 1'b1; byte_data = 8'h5A; end
        @(negedge clk);
        rdy = byte_ready;
        @(posedge clk); #1;
        start_run = 1'b0;
        byte_valid = 1'b0;
        if (collide) begin
            vectors++;
            if (rdy !== 1'b0 || cpu_clk_en !== 1'b1) begin
                miscompares++;
                $display("FAIL collide: byte_ready=%b cpu_clk_en=%b, expected 0 and 1", rdy, cpu_clk_en);
            end
        end
        while (guard < 1000) begin
            @(negedge clk);
            guard++;
            if (done === 1'b1) break;
            if (cpu_clk_en === 1'b1) begin
                if (busy !== 1'b1) busy_bad = 1'b1;
                pc = (en < 256) ? pc_seq[en] : 5'h1F;
                en++;
            end
        end
        vectors++;
        if (en != exp_en || {done, cpu_clk_en, busy, busy_bad} !== 4'b1000) begin
            miscompares++;
            $display("FAIL run_length: enables=%0d done/en/busy/busy_bad=%b, expected %0d and 1000",
                     en, {done, cpu_clk_en, busy, busy_bad}, exp_en);
        end
        pc = 5'h1F;
        @(posedge clk); #1;
    endtask

    task automatic clear_pc_seq();
        for (int k = 0; k < 256; k++) pc_seq[k] = 5'h1F;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({byte_ready, write_ins, cpu_clk_en, busy, done} !== 5'b10000 || ins !== 32'd0 || ins_address !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_state: flags=%b ins=%h addr=%0d, expected 10000 0 0",
                     {byte_ready, write_ins, cpu_clk_en, busy, done}, ins, ins_address);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_collect();
        int base;
        base = wr_cnt;
        send_byte(8'h03);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (ins !== 32'd0 || {byte_ready, busy, done, write_ins} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_mid_collect: ins=%h flags=%b, expected 0 and 1000", ins, {byte_ready, busy, done, write_ins});
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (wr_cnt != base) begin
            miscompares++;
            $display("FAIL reset_no_write: writes=%0d, expected 0", wr_cnt - base);
        end
    endtask

    task automatic test_directed_load();
        prog_words[0] = 32'hF2800004;
        prog_words[1] = 32'hF2801008;
        load_program(2, 1'b0);
    endtask

    task automatic test_run_and_rerun();
        clear_pc_seq();
        do_run(expected_enables(2), 1'b0);
        do_run(expected_enables(2), 1'b0);
    endtask

    task automatic test_done_collision();
        do_run(expected_enables(2), 1'b1);
    endtask

    task automatic test_done_to_idle();
        byte_valid = 1'b1;
        byte_data  = 8'h01;
        @(posedge clk); #1;
        byte_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({byte_ready, done, busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL done_to_idle: rdy/done/busy=%b, expected 100", {byte_ready, done, busy});
        end
        @(posedge clk); #1;
        prog_words[0] = $urandom;
        load_program(1, 1'b0);
    endtask

    task automatic test_zero_and_saturate();
        int   bad;
        do_run(expected_enables(1), 1'b0);
        load_program(0, 1'b0);
        for (int i = 0; i < 32; i++) prog_words[i] = {4'hE, 28'($urandom)};
        load_program(8'h40, 1'b0);
        bad = 0;
        byte_valid = 1'b1;
        byte_data  = 8'h07;
        repeat (3) begin
            @(negedge clk);
            if ({byte_ready, busy, done} !== 3'b000) bad++;
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL loaded_ignores_bytes: %0d bad cycles, expected 0", bad);
        end
        do_run(expected_enables(32), 1'b0);
    endtask

    task automatic test_halt_self_branch();
        for (int i = 0; i < 5; i++) prog_words[i] = {4'hE, 28'($urandom)};
        prog_words[3] = 32'hFAFFFFFE;
        prog_words[4] = 32'hFAFFFFFE;
        load_program(5, 1'b1);
        clear_pc_seq();
        pc_seq[2]  = 5'd4;
        pc_seq[10] = 5'd3;
        do_run(expected_enables(5), 1'b0);
    endtask

    task automatic test_random_programs();
        int n;
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) prog_words[i] = $urandom;
            if ($urandom_range(0, 1) == 1) prog_words[$urandom_range(0, n - 1)] = {4'($urandom), 28'hAFFFFFE};
            for (int k = 0; k < 256; k++) pc_seq[k] = 5'($urandom_range(0, 31));
            load_program(n, 1'b1);
            do_run(expected_enables(n), 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; start_run = 1'b0; pc = 5'h1F;
        clear_pc_seq();
        test_reset();
        test_reset_mid_collect();
        test_directed_load();
        test_run_and_rerun();
        test_done_collision();
        test_done_to_idle();
        test_zero_and_saturate();
        test_halt_self_branch();
        test_random_programs();
        vectors++;
        if (overlap_seen !== 1'b0 || unstable_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL protocol: overlap=%b unstable=%b, expected 0 0", overlap_seen, unstable_seen);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
